// File: rtl/rcpa_error_monitor_if.sv
// Sample/result bundle between a stimulus source and rcpa_error_monitor.
// Optional sq_ed_sum result is present when RCPA_SQERR_EN is defined.
`timescale 1ns/1ps
interface rcpa_error_monitor_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned ACC_W = 32
) ();
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic [N-1:0]     approx_sum;
  logic             fn;
  logic             busy;
  logic             done;
  logic [16:0]      samples;
  logic [16:0]      err_count;
  logic [16:0]      fn_count;
  logic [ACC_W-1:0] sum_ed;
  logic [N:0]       max_ed;
`ifdef RCPA_SQERR_EN
  logic [2*ACC_W-1:0] sq_ed_sum;
`endif

  modport master (
    output start, in_valid, a, b, approx_sum, fn,
    input  in_ready, busy, done, samples, err_count, fn_count, sum_ed, max_ed
`ifdef RCPA_SQERR_EN
    , input sq_ed_sum
`endif
  );

  modport slave (
    input  start, in_valid, a, b, approx_sum, fn,
    output in_ready, busy, done, samples, err_count, fn_count, sum_ed, max_ed
`ifdef RCPA_SQERR_EN
    , output sq_ed_sum
`endif
  );
endinterface

// File: rtl/rcpa_error_monitor.sv
// Accuracy monitor for the approximate adder: batch statistics of error distance.
// Define RCPA_SQERR_EN to also accumulate the sum of squared error distance.
`timescale 1ns/1ps
module rcpa_error_monitor #(
  parameter int unsigned N     = 8,
  parameter int unsigned BATCH = 256,
  parameter int unsigned ACC_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rcpa_error_monitor_if.slave   bus
);
  localparam logic [16:0] BatchCnt = 17'(BATCH);
  localparam int unsigned AccExt   = ACC_W + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;
  state_e state_q, state_d;

  logic             done_q, done_d;
  logic             clear;
  logic             xfer;
  logic             ready;
  logic [16:0]      samples_q, err_count_q, fn_count_q;
  logic [ACC_W-1:0] sum_ed_q;
  logic [N:0]       max_ed_q;

  logic             s1_valid_q;
  logic [N-1:0]     s1_a_q, s1_b_q;
  logic [N:0]       s1_approx_q;

  logic [N:0]       exact;
  logic [N:0]       ed;
  logic [ACC_W:0]   sum_ext;

  assign ready = (state_q == StRun) && (samples_q < BatchCnt);
  assign xfer  = bus.in_valid && ready;

  // Stage 2 arithmetic on the captured sample.
  assign exact   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
  assign ed      = (exact >= s1_approx_q) ? exact - s1_approx_q : s1_approx_q - exact;
  assign sum_ext = {1'b0, sum_ed_q} + AccExt'(ed);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          clear   = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (xfer && (samples_q == BatchCnt - 17'd1)) state_d = StDrain;
      end
      StDrain: begin
        // Registered done lands one edge after stage 1 empties.
        if (!s1_valid_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_approx_q <= '0;
      samples_q   <= '0;
      err_count_q <= '0;
      fn_count_q  <= '0;
      sum_ed_q    <= '0;
      max_ed_q    <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      s1_valid_q <= xfer;
      if (xfer) begin
        s1_a_q      <= bus.a;
        s1_b_q      <= bus.b;
        s1_approx_q <= {bus.fn, bus.approx_sum};
      end
      if (clear) begin
        samples_q   <= '0;
        err_count_q <= '0;
        fn_count_q  <= '0;
        sum_ed_q    <= '0;
        max_ed_q    <= '0;
      end else begin
        if (xfer) samples_q <= samples_q + 17'd1;
        if (s1_valid_q) begin
          if (ed != '0) err_count_q <= err_count_q + 17'd1;
          if (s1_approx_q[N]) fn_count_q <= fn_count_q + 17'd1;
          sum_ed_q <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
          if (ed > max_ed_q) max_ed_q <= ed;
        end
      end
    end
  end

`ifdef RCPA_SQERR_EN
  localparam int unsigned SqW   = 2 * N + 2;
  localparam int unsigned SqExt = 2 * ACC_W + 1;

  logic [SqW-1:0]     sq;
  logic [2*ACC_W:0]   sq_ext;
  logic [2*ACC_W-1:0] sq_ed_sum_q;

  assign sq     = SqW'(ed) * SqW'(ed);
  assign sq_ext = {1'b0, sq_ed_sum_q} + SqExt'(sq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_ed_sum_q <= '0;
    end else if (clear) begin
      sq_ed_sum_q <= '0;
    end else if (s1_valid_q) begin
      sq_ed_sum_q <= sq_ext[2*ACC_W] ? '1 : sq_ext[2*ACC_W-1:0];
    end
  end

  assign bus.sq_ed_sum = sq_ed_sum_q;
`endif

  assign bus.in_ready  = ready;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.samples   = samples_q;
  assign bus.err_count = err_count_q;
  assign bus.fn_count  = fn_count_q;
  assign bus.sum_ed    = sum_ed_q;
  assign bus.max_ed    = max_ed_q;
endmodule

// File: tb/tb_rcpa_error_monitor.sv
// Directed bench for rcpa_error_monitor: a BATCH=4 instance and a BATCH=1 instance.
`timescale 1ns/1ps
module tb_rcpa_error_monitor;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  rcpa_error_monitor_if #(.N(8), .ACC_W(32)) bus4 ();
  rcpa_error_monitor_if #(.N(8), .ACC_W(32)) bus1 ();

  rcpa_error_monitor #(.N(8), .BATCH(4), .ACC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  rcpa_error_monitor #(.N(8), .BATCH(1), .ACC_W(32)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic [7:0] tap,
                      input logic tfn);
    int cnt;
    cnt = 0;
    bus4.a = ta;
    bus4.b = tb_v;
    bus4.approx_sum = tap;
    bus4.fn = tfn;
    bus4.in_valid = 1'b1;
    while (bus4.in_ready !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt >= 20) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b required 1", bus4.in_ready);
    end
    @(negedge clk);
    bus4.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus4.busy, bus4.done, bus4.in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000", {bus4.busy, bus4.done, bus4.in_ready});
    end
    checks++;
    if ({bus4.samples, bus4.err_count, bus4.fn_count, bus4.sum_ed, bus4.max_ed} !== '0) begin
      errors++;
      $display("FAIL reset_stats: samples=%h err=%h fn=%h sum=%h max=%h want all 0",
               bus4.samples, bus4.err_count, bus4.fn_count, bus4.sum_ed, bus4.max_ed);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus4.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: got %b want 0", bus4.in_ready);
    end
  endtask

  task automatic test_exact();
    pulse_start();
    checks++;
    if ({bus4.busy, bus4.in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL exact_run: busy,in_ready got %b want 11", {bus4.busy, bus4.in_ready});
    end
    for (int i = 0; i < 4; i++) send(8'h0F, 8'h01, 8'h10, 1'b0);
    checks++;
    if (bus4.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL exact_ready_drop: got %b want 0", bus4.in_ready);
    end
    checks++;
    if (bus4.done !== 1'b0) begin
      errors++;
      $display("FAIL exact_done_early0: got %b want 0", bus4.done);
    end
    @(negedge clk);
    checks++;
    if (bus4.done !== 1'b0) begin
      errors++;
      $display("FAIL exact_done_early1: got %b want 0", bus4.done);
    end
    @(negedge clk);
    checks++;
    if ({bus4.done, bus4.busy} !== 2'b10) begin
      errors++;
      $display("FAIL exact_done: done,busy got %b want 10", {bus4.done, bus4.busy});
    end
    @(negedge clk);
    checks++;
    if (bus4.done !== 1'b0) begin
      errors++;
      $display("FAIL exact_done_pulse: got %b want 0", bus4.done);
    end
    checks++;
    if ({bus4.samples, bus4.err_count, bus4.fn_count, bus4.sum_ed, bus4.max_ed} !==
        {17'd4, 17'd0, 17'd0, 32'd0, 9'd0}) begin
      errors++;
      $display("FAIL exact_stats: samples=%h err=%h fn=%h sum=%h max=%h want 4,0,0,0,0",
               bus4.samples, bus4.err_count, bus4.fn_count, bus4.sum_ed, bus4.max_ed);
    end
  endtask

  task automatic test_mixed();
    pulse_start();
    checks++;
    if (bus4.samples !== 17'd0) begin
      errors++;
      $display("FAIL mixed_clear: samples got %h want 0", bus4.samples);
    end
    send(8'hFF, 8'h01, 8'h00, 1'b1);
    send(8'h80, 8'h80, 8'h00, 1'b0);
    send(8'h03, 8'h05, 8'h18, 1'b0);
    send(8'hF0, 8'h10, 8'h00, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus4.done !== 1'b1) begin
      errors++;
      $display("FAIL mixed_done: got %b want 1", bus4.done);
    end
    checks++;
    if ({bus4.err_count, bus4.fn_count} !== {17'd2, 17'd2}) begin
      errors++;
      $display("FAIL mixed_counts: err=%h fn=%h want 2,2", bus4.err_count, bus4.fn_count);
    end
    checks++;
    if (bus4.sum_ed !== 32'h110) begin
      errors++;
      $display("FAIL mixed_sum_ed: got %h want 110", bus4.sum_ed);
    end
    checks++;
    if (bus4.max_ed !== 9'h100) begin
      errors++;
      $display("FAIL mixed_max_ed: got %h want 100", bus4.max_ed);
    end
`ifdef RCPA_SQERR_EN
    checks++;
    if (bus4.sq_ed_sum !== 64'h10100) begin
      errors++;
      $display("FAIL mixed_sq_ed_sum: got %h want 10100", bus4.sq_ed_sum);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_gaps();
    logic pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    pulse_start();
    bus4.a = 8'h01;
    bus4.b = 8'h02;
    bus4.approx_sum = 8'h03;
    bus4.fn = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus4.in_valid = pat[i];
      @(negedge clk);
    end
    bus4.in_valid = 1'b1;
    checks++;
    if ({bus4.in_ready, bus4.samples} !== {1'b0, 17'd4}) begin
      errors++;
      $display("FAIL gaps_count: in_ready=%b samples=%h want 0,4", bus4.in_ready, bus4.samples);
    end
    @(negedge clk);
    checks++;
    if (bus4.done !== 1'b0) begin
      errors++;
      $display("FAIL gaps_done_early: got %b want 0", bus4.done);
    end
    @(negedge clk);
    checks++;
    if (bus4.done !== 1'b1) begin
      errors++;
      $display("FAIL gaps_done: got %b want 1", bus4.done);
    end
    bus4.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus4.done, bus4.samples, bus4.err_count} !== {1'b0, 17'd4, 17'd0}) begin
      errors++;
      $display("FAIL gaps_after: done=%b samples=%h err=%h want 0,4,0",
               bus4.done, bus4.samples, bus4.err_count);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send(8'h80, 8'h80, 8'h00, 1'b0);
    send(8'h80, 8'h80, 8'h00, 1'b0);
    checks++;
    if ({bus4.samples, bus4.err_count} !== {17'd2, 17'd1}) begin
      errors++;
      $display("FAIL rstmid_before: samples=%h err=%h want 2,1", bus4.samples, bus4.err_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus4.busy, bus4.in_ready, bus4.samples, bus4.err_count, bus4.max_ed, bus4.sum_ed}
        !== '0) begin
      errors++;
      $display("FAIL rstmid_async: busy=%b rdy=%b samples=%h err=%h max=%h sum=%h want 0",
               bus4.busy, bus4.in_ready, bus4.samples, bus4.err_count, bus4.max_ed,
               bus4.sum_ed);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    for (int i = 0; i < 4; i++) send(8'h0F, 8'h01, 8'h10, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus4.done, bus4.samples, bus4.err_count, bus4.max_ed} !==
        {1'b1, 17'd4, 17'd0, 9'd0}) begin
      errors++;
      $display("FAIL rstmid_clean: done=%b samples=%h err=%h max=%h want 1,4,0,0",
               bus4.done, bus4.samples, bus4.err_count, bus4.max_ed);
    end
    @(negedge clk);
  endtask

  task automatic test_start_busy();
    // start together with in_valid in IDLE: sample must not be taken.
    bus4.a = 8'h80;
    bus4.b = 8'h80;
    bus4.approx_sum = 8'h00;
    bus4.fn = 1'b0;
    bus4.start = 1'b1;
    bus4.in_valid = 1'b1;
    checks++;
    if (bus4.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_start_ready: got %b want 0", bus4.in_ready);
    end
    @(negedge clk);
    bus4.start = 1'b0;
    bus4.in_valid = 1'b0;
    checks++;
    if ({bus4.busy, bus4.samples} !== {1'b1, 17'd0}) begin
      errors++;
      $display("FAIL idle_start_sample: busy=%b samples=%h want 1,0", bus4.busy, bus4.samples);
    end
    send(8'h0F, 8'h01, 8'h10, 1'b0);
    pulse_start();
    checks++;
    if ({bus4.busy, bus4.in_ready, bus4.samples} !== {1'b1, 1'b1, 17'd1}) begin
      errors++;
      $display("FAIL busy_start_ignored: busy=%b rdy=%b samples=%h want 1,1,1",
               bus4.busy, bus4.in_ready, bus4.samples);
    end
    for (int i = 0; i < 3; i++) send(8'h0F, 8'h01, 8'h10, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus4.done, bus4.samples} !== {1'b1, 17'd4}) begin
      errors++;
      $display("FAIL busy_done: done=%b samples=%h want 1,4", bus4.done, bus4.samples);
    end
  endtask

  task automatic test_batch1();
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    checks++;
    if ({bus1.busy, bus1.in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL b1_run: busy,in_ready got %b want 11", {bus1.busy, bus1.in_ready});
    end
    bus1.a = 8'h80;
    bus1.b = 8'h80;
    bus1.approx_sum = 8'h00;
    bus1.fn = 1'b0;
    bus1.in_valid = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    checks++;
    if ({bus1.samples, bus1.in_ready, bus1.done, bus1.busy} !== {17'd1, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b1_xfer: samples=%h rdy=%b done=%b busy=%b want 1,0,0,1",
               bus1.samples, bus1.in_ready, bus1.done, bus1.busy);
    end
    @(negedge clk);
    checks++;
    if (bus1.done !== 1'b0) begin
      errors++;
      $display("FAIL b1_done_early: got %b want 0", bus1.done);
    end
    @(negedge clk);
    checks++;
    if ({bus1.done, bus1.busy, bus1.max_ed} !== {1'b1, 1'b0, 9'h100}) begin
      errors++;
      $display("FAIL b1_done: done=%b busy=%b max=%h want 1,0,100",
               bus1.done, bus1.busy, bus1.max_ed);
    end
    @(negedge clk);
    checks++;
    if (bus1.done !== 1'b0) begin
      errors++;
      $display("FAIL b1_done_pulse: got %b want 0", bus1.done);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus4.start = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.a = '0;
    bus4.b = '0;
    bus4.approx_sum = '0;
    bus4.fn = 1'b0;
    bus1.start = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.a = '0;
    bus1.b = '0;
    bus1.approx_sum = '0;
    bus1.fn = 1'b0;
    @(negedge clk);
    test_reset();
    test_exact();
    test_mixed();
    test_gaps();
    test_reset_mid();
    test_batch1();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rcpa_error_monitor.md
Name: rcpa_error_monitor

Overview:
- Downstream consumer of the N-bit approximate ripple-carry adder (RCPA2) stage.
- Per handshake, samples one operand pair {a, b} together with the adder's approx_sum and fn outputs, computes the exact sum internally, and derives the error distance.
- Accumulates batch statistics over BATCH samples: erroneous count, fn count, summed error distance (ED) and maximum ED.
- Used for on-chip accuracy characterisation of the approximate adder.

Parameters:
- N, 8, operand width; must match the adder under test.
- BATCH, 256, samples per run; legal range 1..2^16.
- ACC_W, 32, width of the sum_ed accumulator.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; begins a new batch.
- in_valid  input  1  sample {a, b, approx_sum, fn} is valid.
- in_ready  output  1  monitor accepts a sample this cycle.
- a  input  N  operand A, as fed to the adder.
- b  input  N  operand B, as fed to the adder.
- approx_sum  input  N  adder sum output.
- fn  input  1  adder final flag output; used as bit N of the approximate result.
- busy  output  1  batch in progress.
- done  output  1  one-cycle pulse when results are final.
- samples  output  17  samples accepted in the current or last batch.
- err_count  output  17  samples with ED != 0.
- fn_count  output  17  samples with fn = 1.
- sum_ed  output  ACC_W  sum of ED, saturating.
- max_ed  output  N+1  maximum ED seen.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the pipeline valid bit is 0. The reset is asynchronous and acts mid-batch: any partial results are discarded.
- Definitions:
  - exact = a + b, N+1 bits.
  - approx = {fn, approx_sum}, N+1 bits.
  - ED = |exact - approx|, N+1 bits.
- States:
  - IDLE: in_ready = 0, busy = 0. On start: clear samples, err_count, fn_count, sum_ed and max_ed; go to RUN; set busy = 1 on the next cycle.
  - RUN: in_ready = 1 while samples < BATCH. A transfer occurs when in_valid && in_ready. On a transfer:
    - register the sample into stage 1 (s1_valid = 1);
    - increment samples in the same edge.
    - When samples reaches BATCH, in_ready drops to 0 in the following cycle.
  - Stage 2, at the next edge after capture:
    - compute ED from the stage-1 registers;
    - err_count += (ED != 0);
    - fn_count += fn;
    - sum_ed += ED, saturating at all-ones;
    - max_ed = max(max_ed, ED).
  - DRAIN: entered after the BATCH-th transfer. Wait until stage 1 is empty, then pulse done for exactly 1 cycle, clear busy and return to IDLE.
- Latency: done asserts 2 cycles after the edge that accepts the last sample.
- Throughput: one sample per cycle; back-to-back transfers are legal.
- Result visibility: statistics are visible continuously during the batch and hold after done until the next start.
- start while busy: ignored; the batch is not restarted.
- start and in_valid in the same cycle in IDLE: the sample is not accepted (in_ready = 0).
- BATCH = 1: a single transfer, then DRAIN; done follows 2 cycles after the transfer.
- in_valid low in RUN: no counting and no state change; gaps between samples are allowed indefinitely.
- Counter widths: 17-bit counters cannot overflow for BATCH <= 2^16.

Optional Feature:
- Macro: RCPA_SQERR_EN.
- Defined:
  - Adds output port sq_ed_sum, width 2*ACC_W.
  - Accumulates ED*ED per sample in stage 2, saturating.
  - Cleared on start and reset to 0.
  - Latency unchanged. Enables MSE = sq_ed_sum / samples off-chip.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (N=8, BATCH=4 unless noted):
- Exact samples: start, then 4 transfers with a=0x0F, b=0x01, approx_sum=0x10, fn=0 -> done 2 cycles after the 4th transfer; samples=4, err_count=0, fn_count=0, sum_ed=0, max_ed=0.
- Mixed errors: send the four samples below -> err_count=2, fn_count=2, sum_ed=0x110, max_ed=0x100.
  - a=0xFF, b=0x01, approx=0x00, fn=1: exact 0x100, ED=0.
  - a=0x80, b=0x80, approx=0x00, fn=0: ED=0x100.
  - a=0x03, b=0x05, approx=0x18, fn=0: exact 0x008, ED=0x10.
  - a=0xF0, b=0x10, approx=0x00, fn=1: ED=0.
- Handshake gaps: toggle in_valid 1,0,0,1,1,0,1 -> exactly 4 samples counted; in_ready=0 after the 4th; a 5th in_valid is not accepted; done pulses once.
- Reset mid-run: assert rst_n=0 after 2 transfers -> all outputs 0 immediately (asynchronous); a new start runs a clean batch with samples=4 at done.
- start while busy and BATCH=1: a start pulse during RUN is ignored (samples continue). With BATCH=1, a single transfer gives done 2 cycles later and busy falls with done.
- RCPA_SQERR_EN defined, mixed-errors stimulus -> sq_ed_sum = 0x10000 + 0x100 = 0x10100. Undefined -> build succeeds without the port.
